// File: rtl/intersection_pkg.sv
// Shared types and phase-length helpers for the intersection scheduler.
// INTERSECTION_FLASH_EN adds the FLASH state to the state enum.
package intersection_pkg;

  typedef enum logic [2:0] {
    S_ALLRED_A,
    S_NS_GREEN,
    S_NS_YELLOW,
    S_ALLRED_B,
    S_EW_GREEN,
    S_EW_YELLOW,
    S_WALK
`ifdef INTERSECTION_FLASH_EN
    , S_FLASH
`endif
  } state_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED = lamp_t'(3'b100);
  localparam lamp_t LAMP_YEL = lamp_t'(3'b010);
  localparam lamp_t LAMP_GRN = lamp_t'(3'b001);

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic int unsigned max4(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int unsigned phase_len(
    input state_t      s,
    input int unsigned g,
    input int unsigned y,
    input int unsigned a,
    input int unsigned w
  );
    int unsigned n;
    n = a;
    unique case (s)
      S_NS_GREEN, S_EW_GREEN:   n = g;
      S_NS_YELLOW, S_EW_YELLOW: n = y;
      S_WALK:                   n = w;
      default:                  n = a;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Loadable phase down-counter; expire is high while the count is zero.
// Load takes priority over the enabled decrement.
module phase_timer #(
  parameter int          W       = 6,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// NS/EW intersection scheduler with all-red clearance and pedestrian walk.
// Define INTERSECTION_FLASH_EN to add the flash input and FLASH state.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned YELLOW_CYCLES = 7,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned WALK_CYCLES   = 10
`ifdef INTERSECTION_FLASH_EN
  , parameter int unsigned FLASH_HALF  = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic ped_req,
`ifdef INTERSECTION_FLASH_EN
  input  logic flash,
`endif
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_ack
);

  localparam int unsigned MAXC =
    max4(GREEN_CYCLES, YELLOW_CYCLES,
         ALLRED_CYCLES, WALK_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] RST_CNT =
    CW'(ALLRED_CYCLES - 1);

  state_t state_q, state_d;
  logic   dir_q, dir_d;
  logic   pend_q;
  logic   ack_q;
  logic   expire;
  logic   load;
  logic   walk_entry;
  logic [CW-1:0] load_val;
  lamp_t  ns_l, ew_l;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (enable && expire) begin
      unique case (state_q)
        S_ALLRED_A: begin
          if (pend_q) begin
            state_d = S_WALK;
            dir_d   = DIR_NS;
          end else begin
            state_d = S_NS_GREEN;
          end
        end
        S_NS_GREEN:  state_d = S_NS_YELLOW;
        S_NS_YELLOW: state_d = S_ALLRED_B;
        S_ALLRED_B: begin
          if (pend_q) begin
            state_d = S_WALK;
            dir_d   = DIR_EW;
          end else begin
            state_d = S_EW_GREEN;
          end
        end
        S_EW_GREEN:  state_d = S_EW_YELLOW;
        S_EW_YELLOW: state_d = S_ALLRED_A;
        S_WALK: begin
          state_d = (dir_q == DIR_EW) ? S_EW_GREEN
                                      : S_NS_GREEN;
        end
        default:     state_d = S_ALLRED_A;
      endcase
    end
`ifdef INTERSECTION_FLASH_EN
    // Flash overrides everything, even a frozen timer.
    if (flash) begin
      state_d = S_FLASH;
    end else if (state_q == S_FLASH) begin
      state_d = S_ALLRED_A;
      dir_d   = DIR_NS;
    end
`endif
  end

  assign load       = (state_d != state_q);
  assign walk_entry = (state_d == S_WALK) &&
                      (state_q != S_WALK);
  assign load_val   = CW'(phase_len(state_d,
                        GREEN_CYCLES, YELLOW_CYCLES,
                        ALLRED_CYCLES, WALK_CYCLES) - 1);

  phase_timer #(
    .W       (CW),
    .RST_VAL (RST_CNT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (enable),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ALLRED_A;
      dir_q   <= DIR_NS;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ack_q   <= walk_entry;
      if (walk_entry) begin
        pend_q <= 1'b0;
      end else if (ped_req && state_q != S_WALK) begin
        pend_q <= 1'b1;
      end
    end
  end

`ifdef INTERSECTION_FLASH_EN
  localparam int FW = $clog2(FLASH_HALF) + 1;

  logic [FW-1:0] fcnt_q;
  logic          fon_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != S_FLASH) begin
      fcnt_q <= '0;
      fon_q  <= 1'b1;
    end else if (fcnt_q == FW'(FLASH_HALF - 1)) begin
      fcnt_q <= '0;
      fon_q  <= ~fon_q;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end
`endif

  always_comb begin
    ns_l = LAMP_RED;
    ew_l = LAMP_RED;
    unique case (state_q)
      S_NS_GREEN:  ns_l = LAMP_GRN;
      S_NS_YELLOW: ns_l = LAMP_YEL;
      S_EW_GREEN:  ew_l = LAMP_GRN;
      S_EW_YELLOW: ew_l = LAMP_YEL;
`ifdef INTERSECTION_FLASH_EN
      S_FLASH: begin
        ns_l = '{red: 1'b0, yellow: fon_q, green: 1'b0};
        ew_l = '{red: 1'b0, yellow: fon_q, green: 1'b0};
      end
`endif
      default: ;
    endcase
  end

  assign {ns_red, ns_yellow, ns_green} = ns_l;
  assign {ew_red, ew_yellow, ew_green} = ew_l;
  assign walk    = (state_q == S_WALK);
  assign ped_ack = ack_q;

endmodule
